// File: rtl/daw_pkg.sv
// Shared DAW definitions: mixer FSM states, accumulator sizing and gain constants.
package daw_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } mixer_state_t;

    // Wide enough for CHANNELS full-scale products at maximum gain plus a sign guard bit.
    function automatic int unsigned mix_acc_width(input int unsigned word_width,
                                                  input int unsigned gain_width,
                                                  input int unsigned channels);
        return word_width + gain_width + $clog2(channels) + 1;
    endfunction

    function automatic int unsigned mix_unity_gain(input int unsigned gain_width);
        return 32'd1 << (gain_width - 1);
    endfunction

    localparam int unsigned MIX_GAIN_WIDTH_DEFAULT = 4;
    localparam int unsigned MIX_UNITY_GAIN         = mix_unity_gain(MIX_GAIN_WIDTH_DEFAULT);

endpackage

// File: rtl/track_mixer_if.sv
// Frame-in / mixed-word-out bus between the track loader and the mixer.
interface track_mixer_if #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned GAIN_WIDTH = 4
);
    logic                                 sample_valid;
    logic [CHANNELS-1:0][WORD_WIDTH-1:0]  samples;
    logic [CHANNELS-1:0][GAIN_WIDTH-1:0]  gain;
    logic [CHANNELS-1:0]                  mute_mask;
    logic                                 clip_clr;
    logic signed [WORD_WIDTH-1:0]         mix_out;
    logic                                 mix_valid;
    logic                                 busy;
    logic                                 clipped;
    logic                                 dropped;

    modport master (
        output sample_valid, samples, gain, mute_mask, clip_clr,
        input  mix_out, mix_valid, busy, clipped, dropped
    );

    modport slave (
        input  sample_valid, samples, gain, mute_mask, clip_clr,
        output mix_out, mix_valid, busy, clipped, dropped
    );
endinterface

// File: rtl/mix_range_reduce.sv
// Reduces a scaled accumulator to WORD_WIDTH and flags out-of-range values.
// TRACK_MIXER_SATURATE_EN defined: clamp; otherwise two's-complement wrap.
module mix_range_reduce #(
    parameter int unsigned ACC_W      = 16,
    parameter int unsigned WORD_WIDTH = 8
) (
    input  logic signed [ACC_W-1:0]      scaled,
    output logic signed [WORD_WIDTH-1:0] word_c,
    output logic                         out_of_range_c
);
    localparam int unsigned HI_W = ACC_W - WORD_WIDTH + 1;

    logic [HI_W-1:0] upper;

    assign upper = scaled[ACC_W-1:WORD_WIDTH-1];

    // In range only when every bit above the result's sign bit matches it.
    always_comb begin
        out_of_range_c = !((&upper) || !(|upper));
        word_c         = scaled[WORD_WIDTH-1:0];
`ifdef TRACK_MIXER_SATURATE_EN
        if (out_of_range_c) begin
            word_c = scaled[ACC_W-1] ? {1'b1, {(WORD_WIDTH-1){1'b0}}}
                                     : {1'b0, {(WORD_WIDTH-1){1'b1}}};
        end
`else
`endif
    end
endmodule

// File: rtl/track_mixer.sv
// Time-multiplexed multitrack mixer: capture a frame, MAC one channel per cycle, emit a rescaled word.
// Optional clamping of out-of-range results via TRACK_MIXER_SATURATE_EN.
module track_mixer
    import daw_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned GAIN_WIDTH = 4
) (
    input logic           clk,
    input logic           rst,
    track_mixer_if.slave  mif
);
    localparam int unsigned ACC_W  = mix_acc_width(WORD_WIDTH, GAIN_WIDTH, CHANNELS);
    localparam int unsigned IDX_W  = $clog2(CHANNELS);
    localparam int unsigned PROD_W = WORD_WIDTH + GAIN_WIDTH + 1;

    mixer_state_t                         state;
    logic signed [ACC_W-1:0]              acc;
    logic [IDX_W-1:0]                     idx;
    logic [CHANNELS-1:0][WORD_WIDTH-1:0]  samp_q;
    logic [CHANNELS-1:0][GAIN_WIDTH-1:0]  gain_q;
    logic [CHANNELS-1:0]                  mute_q;

    logic signed [WORD_WIDTH-1:0]  cur_samp;
    logic signed [GAIN_WIDTH:0]    cur_gain;
    logic signed [PROD_W-1:0]      product;
    logic signed [ACC_W-1:0]       term;
    logic signed [ACC_W-1:0]       scaled;
    logic signed [WORD_WIDTH-1:0]  reduced;
    logic                          out_of_range;
    logic                          last_ch;

    // Gain is zero-extended so the multiply stays signed x non-negative.
    assign cur_samp = samp_q[idx];
    assign cur_gain = signed'({1'b0, gain_q[idx]});
    assign product  = cur_samp * cur_gain;
    assign term     = mute_q[idx] ? '0 : ACC_W'(product);
    assign scaled   = acc >>> (GAIN_WIDTH - 1);
    assign last_ch  = (idx == IDX_W'(CHANNELS - 1));

    mix_range_reduce #(
        .ACC_W      (ACC_W),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_range (
        .scaled         (scaled),
        .word_c         (reduced),
        .out_of_range_c (out_of_range)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            idx           <= '0;
            samp_q        <= '0;
            gain_q        <= '0;
            mute_q        <= '0;
            mif.mix_out   <= '0;
            mif.mix_valid <= 1'b0;
            mif.busy      <= 1'b0;
            mif.clipped   <= 1'b0;
            mif.dropped   <= 1'b0;
        end else begin
            mif.mix_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (mif.sample_valid) begin
                        samp_q   <= mif.samples;
                        gain_q   <= mif.gain;
                        mute_q   <= mif.mute_mask;
                        acc      <= '0;
                        idx      <= '0;
                        mif.busy <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + term;
                    idx <= idx + IDX_W'(1);
                    if (last_ch) begin
                        state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    mif.mix_out   <= reduced;
                    mif.mix_valid <= 1'b1;
                    mif.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Sticky flags: a set event outranks a simultaneous clear.
            if (mif.sample_valid && (state != IDLE)) begin
                mif.dropped <= 1'b1;
            end else if (mif.clip_clr) begin
                mif.dropped <= 1'b0;
            end

            if ((state == OUTPUT) && out_of_range) begin
                mif.clipped <= 1'b1;
            end else if (mif.clip_clr) begin
                mif.clipped <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_track_mixer.sv
// Directed self-checking bench for track_mixer (WORD_WIDTH=8, CHANNELS=8, GAIN_WIDTH=4).
module tb_track_mixer;
    import daw_pkg::*;

    localparam int unsigned WW = 8;
    localparam int unsigned CH = 8;
    localparam int unsigned GW = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    track_mixer_if #(.WORD_WIDTH(WW), .CHANNELS(CH), .GAIN_WIDTH(GW)) mif ();

    track_mixer #(.WORD_WIDTH(WW), .CHANNELS(CH), .GAIN_WIDTH(GW)) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Channel 0 gets s0/g0, all other channels get so/go.
    task automatic load(input int s0, input int so, input int g0, input int go,
                        input logic [CH-1:0] mute);
        for (int i = 0; i < int'(CH); i++) begin
            mif.samples[i] = (i == 0) ? WW'(s0) : WW'(so);
            mif.gain[i]    = (i == 0) ? GW'(g0) : GW'(go);
        end
        mif.mute_mask = mute;
    endtask

    // Strobe the loaded frame, then check latency, result and busy timing.
    task automatic run_frame(input string tag, input int exp_val);
        int n;
        n = 0;
        mif.sample_valid = 1'b1;
        step();
        mif.sample_valid = 1'b0;
        check({tag, " busy_rise"}, 32'(mif.busy), 1);
        while ((n < 20) && !mif.mix_valid) begin
            step();
            n++;
        end
        check({tag, " latency"}, n, 9);
        check({tag, " mix_out"}, mif.mix_out, exp_val);
        check({tag, " busy_fall"}, 32'(mif.busy), 0);
    endtask

    task automatic pulse_clip_clr();
        mif.clip_clr = 1'b1;
        step();
        mif.clip_clr = 1'b0;
    endtask

    initial begin
        int pulses;
        int last_val;
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        mif.sample_valid = 1'b0;
        mif.clip_clr     = 1'b0;
        load(0, 0, 0, 0, '0);
        step();
        step();

        check("rst mix_out", mif.mix_out, 0);
        check("rst mix_valid", 32'(mif.mix_valid), 0);
        check("rst busy", 32'(mif.busy), 0);
        check("rst clipped", 32'(mif.clipped), 0);
        check("rst dropped", 32'(mif.dropped), 0);
        rst = 1'b0;
        step();

        // Case 1: unity gain, 8 x 10 -> 80
        load(10, 10, MIX_UNITY_GAIN, MIX_UNITY_GAIN, '0);
        run_frame("c1", 80);
        check("c1 clipped", 32'(mif.clipped), 0);
        step();
        check("c1 valid_one_cycle", 32'(mif.mix_valid), 0);

        // Case 2: positive overflow, scaled = 800
        load(100, 100, 8, 8, '0);
`ifdef TRACK_MIXER_SATURATE_EN
        run_frame("c2", 127);
`else
        run_frame("c2", 32);
`endif
        check("c2 clipped", 32'(mif.clipped), 1);
        pulse_clip_clr();
        check("c2 clip_clr", 32'(mif.clipped), 0);

        // Case 3: negative overflow, scaled = -800
        load(-100, -100, 8, 8, '0);
`ifdef TRACK_MIXER_SATURATE_EN
        run_frame("c3", -128);
`else
        run_frame("c3", -32);
`endif
        check("c3 clipped", 32'(mif.clipped), 1);
        pulse_clip_clr();

        // Case 4: only ch0 live, -5*15 = -75, floor(-75/8) = -10
        load(-5, 50, 15, 8, 8'hFE);
        run_frame("c4", -10);
        check("c4 clipped", 32'(mif.clipped), 0);

        // Case 5: second strobe three cycles after the first is dropped
        load(10, 10, 8, 8, '0);
        mif.sample_valid = 1'b1;
        step();
        load(-5, 50, 15, 8, 8'hFE);
        mif.sample_valid = 1'b0;
        step();
        step();
        mif.sample_valid = 1'b1;
        step();
        mif.sample_valid = 1'b0;
        pulses   = 0;
        last_val = 0;
        for (int i = 0; i < 12; i++) begin
            if (mif.mix_valid) begin
                pulses++;
                last_val = int'(mif.mix_out);
            end
            step();
        end
        check("c5 pulses", pulses, 1);
        check("c5 first_frame", last_val, 80);
        check("c5 dropped", 32'(mif.dropped), 1);
        pulse_clip_clr();
        check("c5 dropped_clr", 32'(mif.dropped), 0);

        // Case 5b: strobe in the mix_valid cycle is accepted (12*64/8 = 96)
        load(10, 10, 8, 8, '0);
        run_frame("c5b_a", 80);
        load(12, 12, 8, 8, '0);
        run_frame("c5b_b", 96);
        check("c5b dropped", 32'(mif.dropped), 0);

        // Case 6: reset during ACCUM aborts the frame
        load(10, 10, 8, 8, '0);
        mif.sample_valid = 1'b1;
        step();
        mif.sample_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("c6 busy", 32'(mif.busy), 0);
        check("c6 mix_out", mif.mix_out, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (mif.mix_valid) pulses++;
            step();
        end
        check("c6 no_pulse", pulses, 0);
        run_frame("c6_after", 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
